// File: rtl/led_fx_pkg.sv
// Shared constants and types for the LED fade driver.
// Default brightness width, decay step and PWM prescale.
package led_fx_pkg;

   localparam int LED_BW        = 4;
   localparam int LED_MAX_LEVEL = (1 << LED_BW) - 1;
   localparam int LED_DECAY     = 4;
   localparam int LED_PWM_DIV   = 16;

   typedef logic [LED_BW-1:0] level_t;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED: brightness level, period-latched shadow copy
// and the PWM comparator that drives the pin.
module led_pwm_channel
   import led_fx_pkg::*;
#(
   parameter int BW    = LED_BW,
   parameter int DECAY = LED_DECAY
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_step,
   input  logic          i_fade_en,
   input  logic          i_pat,
   input  logic          i_commit,
   input  logic [BW-1:0] i_pwm_cnt,
   output logic          o_led
);

   localparam int MAXL = (1 << BW) - 1;

   logic [BW-1:0] r_bright;
   logic [BW-1:0] r_shadow;
   logic          r_led;
   logic [BW-1:0] w_decayed;

   // Saturate at zero instead of wrapping back to full.
   always_comb begin
      w_decayed = '0;
      if (r_bright > BW'(DECAY))
         w_decayed = r_bright - BW'(DECAY);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bright <= '0;
         r_shadow <= '0;
         r_led    <= 1'b0;
      end else begin
         if (!i_fade_en)
            r_bright <= i_pat ? BW'(MAXL) : '0;
         else if (i_step)
            r_bright <= i_pat ? BW'(MAXL) : w_decayed;
         if (i_commit)
            r_shadow <= r_bright;
         r_led <= (r_shadow > i_pwm_cnt);
      end
   end

   assign o_led = r_led;

endmodule

// File: rtl/led_fade_driver.sv
// Comet-tail LED driver: step edge detect, PWM timebase
// and eight brightness channels.
module led_fade_driver
   import led_fx_pkg::*;
#(
   parameter int BW      = LED_BW,
   parameter int DECAY   = LED_DECAY,
   parameter int PWM_DIV = LED_PWM_DIV
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       step_in,
   input  logic [7:0] pattern_in,
   input  logic       fade_en,
   output logic [7:0] led
);

   localparam int MAXL = (1 << BW) - 1;
   localparam int PW   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

   logic [PW-1:0] r_pre_cnt;
   logic [BW-1:0] r_pwm_cnt;
   logic          r_step_d;

   logic w_step_pulse;
   logic w_pwm_adv;
   logic w_wrap;
   logic w_commit;

   assign w_step_pulse = step_in & ~r_step_d;
   assign w_pwm_adv    = (r_pre_cnt == PW'(PWM_DIV - 1));
   assign w_wrap       = (r_pwm_cnt == BW'(MAXL - 1));
   // Levels only reach the comparators at a period boundary.
   assign w_commit     = w_pwm_adv & w_wrap;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pre_cnt <= '0;
         r_pwm_cnt <= '0;
         r_step_d  <= 1'b0;
      end else begin
         r_step_d <= step_in;
         if (w_pwm_adv) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= w_wrap ? '0 : r_pwm_cnt + 1'b1;
         end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
         end
      end
   end

   for (genvar gi = 0; gi < 8; gi++) begin : g_ch
      led_pwm_channel #(
         .BW    (BW),
         .DECAY (DECAY)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .i_step    (w_step_pulse),
         .i_fade_en (fade_en),
         .i_pat     (pattern_in[gi]),
         .i_commit  (w_commit),
         .i_pwm_cnt (r_pwm_cnt),
         .o_led     (led[gi])
      );
   end

endmodule
